// File: rtl/nrisc_reg_bank.sv
// 16-entry register bank with a write-back port, two bypassed combinational read ports,
// and a per-register pending-write scoreboard for read-after-write hazard detection.
module nrisc_reg_bank #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wb_en,
  input  logic [3:0]     wb_sel,
  input  logic [TAM-1:0] wb_data,
  input  logic [3:0]     rd_selA,
  input  logic [3:0]     rd_selB,
  output logic [TAM-1:0] rd_A,
  output logic [TAM-1:0] rd_B,
  input  logic           rsv_en,
  input  logic [3:0]     rsv_sel,
  output logic           busyA,
  output logic           busyB,
  output logic [15:0]    busy_vec
);

  logic [TAM-1:0] regs_q [16];
  logic [TAM-1:0] regs_d [16];
  logic [15:0]    busy_q;
  logic [15:0]    busy_d;
  logic           hit_a;
  logic           hit_b;

  // Reserve is applied after the write-back clear so it wins on a same-index collision.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    busy_d = busy_q;
    if (wb_en) begin
      regs_d[wb_sel] = wb_data;
      busy_d[wb_sel] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Bypass is suppressed during reset so the read ports stay at zero while rst_n is low.
  assign hit_a = rst_n && wb_en && (wb_sel == rd_selA);
  assign hit_b = rst_n && wb_en && (wb_sel == rd_selB);

  assign rd_A     = hit_a ? wb_data : regs_q[rd_selA];
  assign rd_B     = hit_b ? wb_data : regs_q[rd_selB];
  assign busyA    = busy_q[rd_selA] && !hit_a;
  assign busyB    = busy_q[rd_selB] && !hit_b;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_nrisc_reg_bank.sv
// Self-checking bench for nrisc_reg_bank: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register bank.
module tb_nrisc_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  wb_sel;
  logic [15:0] wb_data;
  logic [3:0]  rd_selA;
  logic [3:0]  rd_selB;
  logic [15:0] rd_A;
  logic [15:0] rd_B;
  logic        rsv_en;
  logic [3:0]  rsv_sel;
  logic        busyA;
  logic        busyB;
  logic [15:0] busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_regs [16];
  bit          m_busy [16];

  nrisc_reg_bank #(.TAM(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .rd_selA(rd_selA), .rd_selB(rd_selB), .rd_A(rd_A), .rd_B(rd_B),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .busyA(busyA), .busyB(busyB), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] sel);
    if (!rst_n) return 16'h0;
    if (wb_en && wb_sel == sel) return wb_data;
    return m_regs[sel];
  endfunction

  function automatic logic m_busy_rd(input logic [3:0] sel);
    if (!rst_n) return 1'b0;
    return m_busy[sel] && !(wb_en && wb_sel == sel);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] ws, input logic [15:0] wd,
                       input logic re, input logic [3:0] rs,
                       input logic [3:0] ra, input logic [3:0] rb);
    wb_en = we; wb_sel = ws; wb_data = wd;
    rsv_en = re; rsv_sel = rs;
    rd_selA = ra; rd_selB = rb;
  endtask

  // Checks combinational outputs mid-cycle, then advances one clock and updates the model.
  task automatic tick(input bit do_check);
    @(negedge clk);
    if (do_check) begin
      check("rd_A", rd_A, m_read(rd_selA));
      check("rd_B", rd_B, m_read(rd_selB));
      check("busyA", busyA, m_busy_rd(rd_selA));
      check("busyB", busyB, m_busy_rd(rd_selB));
      check("busy_vec", busy_vec, rst_n ? m_vec() : 16'h0);
    end
    @(posedge clk);
    if (rst_n) begin
      if (wb_en) begin
        m_regs[wb_sel] = wb_data;
        m_busy[wb_sel] = 1'b0;
      end
      if (rsv_en) m_busy[rsv_sel] = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #3;
    check("reset_rdA", rd_A, 16'h0);
    check("reset_busy_vec", busy_vec, 16'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with all-ones and reserve everything, then reset asynchronously mid-cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 16'hFFFF, 1, 4'(i), 4'(i), 4'(15 - i));
      tick(1);
    end
    drive(0, 0, 0, 0, 0, 4'd3, 4'd12);
    check("prefill_rdA", rd_A, 16'hFFFF);
    check("prefill_busy", busy_vec, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("async_rst_rdA", rd_A, 16'h0);
    check("async_rst_rdB", rd_B, 16'h0);
    check("async_rst_busy", busy_vec, 16'h0);
    // Write and reserve coincident with an edge held in reset must be discarded.
    drive(1, 4'd3, 16'hBEEF, 1, 4'd3, 4'd3, 4'd3);
    tick(1);
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd3, 4'd3);
    #1;
    check("rst_discard_rd", rd_A, 16'h0);
    check("rst_discard_busy", busy_vec, 16'h0);
    @(posedge clk); #1;

    // Write/read-back sweep.
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 16'h1000 + 16'(i), 0, 0, 0, 0);
      tick(0);
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
      #1;
      check("sweep_A", rd_A, 16'h1000 + 16'(i));
      check("sweep_B", rd_B, 16'h1000 + 16'(15 - i));
      tick(1);
    end

    // Bypass.
    drive(1, 4'd5, 16'hAAAA, 0, 0, 0, 0);
    tick(1);
    drive(1, 4'd5, 16'h5555, 0, 0, 4'd5, 4'd5);
    #1;
    check("bypass_A", rd_A, 16'h5555);
    check("bypass_B", rd_B, 16'h5555);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd5, 4'd5);
    #1;
    check("bypass_stored", rd_A, 16'h5555);

    // Scoreboard lifecycle.
    drive(0, 0, 0, 1, 4'd3, 4'd3, 4'd0);
    #1;
    check("rsv_same_cycle_busyA", busyA, 1'b0);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd3, 4'd0);
    #1;
    check("rsv_vec", busy_vec, 16'h0008);
    check("rsv_busyA", busyA, 1'b1);
    tick(1);
    drive(1, 4'd3, 16'h0333, 0, 0, 4'd3, 4'd3);
    #1;
    check("wb_busyA_clear", busyA, 1'b0);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd3, 4'd3);
    #1;
    check("wb_vec_clear", busy_vec, 16'h0000);

    // Collision: reserve and write-back to the same busy register.
    drive(0, 0, 0, 1, 4'd7, 4'd7, 4'd7);
    tick(1);
    drive(1, 4'd7, 16'h0042, 1, 4'd7, 4'd7, 4'd7);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd7, 4'd7);
    #1;
    check("collide_data", rd_A, 16'h0042);
    check("collide_busy", busy_vec[7], 1'b1);
    drive(1, 4'd7, 16'h0043, 0, 0, 4'd7, 4'd7);
    tick(1);

    // Parallel reserve and write-back to different registers.
    drive(0, 0, 0, 1, 4'd2, 4'd2, 4'd9);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd2, 4'd9);
    #1;
    check("par_pre", busy_vec, 16'h0004);
    drive(1, 4'd2, 16'h2222, 1, 4'd9, 4'd2, 4'd9);
    tick(1);
    drive(0, 0, 0, 0, 0, 4'd2, 4'd9);
    #1;
    check("par_post", busy_vec, 16'h0200);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
